// File: rtl/blk2byte_fifo.sv
// blk2byte_fifo: wide-to-narrow FIFO. Whole 512-bit blocks are written into
// BLK_DEPTH slots and streamed out one byte per pop on a first-word-fall-through
// read port. The block being streamed lives in a shift register outside the slots.
// Optional: define BLK2BYTE_ERR_FLAGS_EN to add sticky o_ovf / o_udf flags.
module blk2byte_fifo #(
  parameter int unsigned BLK_DEPTH = 4,
  parameter int unsigned CNT_W     = 9
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_en,
  input  logic [511:0]                i_data,
  output logic                        o_full,
  input  logic                        i_rd_en,
  output logic [7:0]                  o_data,
  output logic                        o_data_vld,
  output logic [CNT_W-1:0]            o_data_cnt,
  output logic [$clog2(BLK_DEPTH):0]  o_blk_cnt
`ifdef BLK2BYTE_ERR_FLAGS_EN
  ,
  output logic                        o_ovf,
  output logic                        o_udf
`endif
);

  localparam int unsigned AW = $clog2(BLK_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  logic [511:0]     mem_q [BLK_DEPTH];
  state_t           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [511:0]     sh_q, sh_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    blk_cnt_q, blk_cnt_d;
  logic             full_q, full_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
  logic             wr_acc, pop, last_pop, load;

  // Byte j of the stream is byte (3 - j%4) of 32-bit word j/4 (big-endian words).
  function automatic logic [511:0] reorder(input logic [511:0] b);
    logic [511:0] r;
    r = '0;
    for (int j = 0; j < 64; j++) begin
      r[8*j +: 8] = b[32*(j/4) + 31 - 8*(j%4) -: 8];
    end
    return r;
  endfunction

  // Block storage; written only on accepted writes.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      sh_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      blk_cnt_q  <= '0;
      full_q     <= 1'b0;
      vld_q      <= 1'b0;
      data_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      blk_cnt_q  <= blk_cnt_d;
      full_q     <= full_d;
      vld_q      <= vld_d;
      data_cnt_q <= data_cnt_d;
    end
  end

  // Next-state: write acceptance, byte pops and back-to-back block loads.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    rd_ptr_d = rd_ptr_q;
    wr_acc   = i_wr_en && !full_q;
    pop      = i_rd_en && (state_q == STREAM);
    last_pop = pop && (idx_q == 6'd63);
    load     = (blk_cnt_q != '0) && ((state_q == IDLE) || last_pop);
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);

    case (state_q)
      IDLE: ;
      STREAM: begin
        if (pop) begin
          sh_d  = sh_q >> 8;
          idx_d = idx_q + 6'd1;
          if (last_pop) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sh_d     = reorder(mem_q[rd_ptr_q[AW-1:0]]);
      rd_ptr_d = rd_ptr_q + PW'(1);
      idx_d    = '0;
      state_d  = STREAM;
    end

    blk_cnt_d  = wr_ptr_d - rd_ptr_d;
    full_d     = (blk_cnt_d == PW'(BLK_DEPTH));
    vld_d      = (state_d == STREAM);
    data_cnt_d = CNT_W'(32'(blk_cnt_d) * 32'd64 +
                        ((state_d == STREAM) ? (32'd64 - 32'(idx_d)) : 32'd0));
  end

  assign o_data     = sh_q[7:0];
  assign o_data_vld = vld_q;
  assign o_full     = full_q;
  assign o_data_cnt = data_cnt_q;
  assign o_blk_cnt  = blk_cnt_q;

`ifdef BLK2BYTE_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  // Sticky illegal-request flags, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (i_wr_en & full_q);
      udf_q <= udf_q | (i_rd_en & ~vld_q);
    end
  end

  assign o_ovf = ovf_q;
  assign o_udf = udf_q;
`endif

endmodule

// File: tb/tb_blk2byte_fifo.sv
// Self-checking bench for blk2byte_fifo: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_blk2byte_fifo;
  localparam int unsigned D     = 4;
  localparam int unsigned CNT_W = 9;

  logic         i_clk = 1'b0;
  logic         i_rst, i_wr_en, i_rd_en;
  logic [511:0] i_data;
  logic         o_full, o_data_vld;
  logic [7:0]   o_data;
  logic [CNT_W-1:0] o_data_cnt;
  logic [$clog2(D):0] o_blk_cnt;
`ifdef BLK2BYTE_ERR_FLAGS_EN
  logic o_ovf, o_udf;
`endif

  blk2byte_fifo #(.BLK_DEPTH(D), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_data(i_data),
    .o_full(o_full), .i_rd_en(i_rd_en), .o_data(o_data),
    .o_data_vld(o_data_vld), .o_data_cnt(o_data_cnt), .o_blk_cnt(o_blk_cnt)
`ifdef BLK2BYTE_ERR_FLAGS_EN
    , .o_ovf(o_ovf), .o_udf(o_udf)
`endif
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of stored blocks plus queue of bytes still to stream.
  logic [511:0] m_blks[$];
  logic [7:0]   m_bytes[$];
  bit           m_ovf, m_udf;
  bit           m_live = 1'b0;

  // Big-endian 32-bit words, emitted word 0 first.
  task automatic m_expand(input logic [511:0] b);
    logic [31:0] w;
    for (int k = 0; k < 16; k++) begin
      w = b[32*k +: 32];
      m_bytes.push_back(w[31:24]);
      m_bytes.push_back(w[23:16]);
      m_bytes.push_back(w[15:8]);
      m_bytes.push_back(w[7:0]);
    end
  endtask

  // Model advances on each rising edge using the pre-edge inputs.
  always @(posedge i_clk) begin
    bit had_blk, was_full, was_vld;
    if (i_rst) begin
      m_blks.delete();
      m_bytes.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      had_blk  = (m_blks.size() > 0);
      was_full = (m_blks.size() == D);
      was_vld  = (m_bytes.size() > 0);
      if (i_wr_en && was_full) m_ovf = 1'b1;
      if (i_rd_en && !was_vld) m_udf = 1'b1;
      if (i_rd_en && was_vld) void'(m_bytes.pop_front());
      if (m_bytes.size() == 0 && had_blk) m_expand(m_blks.pop_front());
      if (i_wr_en && !was_full) m_blks.push_back(i_data);
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge i_clk) begin
    if (m_live) begin
      chk("vld", 32'(o_data_vld), 32'(m_bytes.size() > 0));
      chk("blk_cnt", 32'(o_blk_cnt), 32'(m_blks.size()));
      chk("full", 32'(o_full), 32'(m_blks.size() == D));
      chk("data_cnt", 32'(o_data_cnt), 32'(64 * m_blks.size() + m_bytes.size()));
      if (m_bytes.size() > 0) chk("data", 32'(o_data), 32'(m_bytes[0]));
`ifdef BLK2BYTE_ERR_FLAGS_EN
      chk("ovf", 32'(o_ovf), 32'(m_ovf));
      chk("udf", 32'(o_udf), 32'(m_udf));
`endif
    end
  end

  function automatic logic [511:0] pattern();
    logic [511:0] p;
    for (int k = 0; k < 16; k++)
      p[32*k +: 32] = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
    return p;
  endfunction

  function automatic logic [511:0] rnd_blk();
    logic [511:0] p;
    for (int k = 0; k < 16; k++) p[32*k +: 32] = $urandom;
    return p;
  endfunction

  task automatic idle_inputs();
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    i_rst   = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_wr_en = 1'b0; i_rd_en = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (o_data_vld && n < 400) begin
      i_rd_en = 1'b1;
      @(negedge i_clk);
      n++;
    end
    i_rd_en = 1'b0;
    chk(name, 32'(o_data_vld), 32'd0);
  endtask

  initial begin
    i_data = '0;
    i_rst = 1'b1; i_wr_en = 1'b0; i_rd_en = 1'b0;
    @(negedge i_clk);
    // Reset values
    chk("rst_vld", 32'(o_data_vld), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_cnt", 32'(o_data_cnt), 32'd0);
    chk("rst_blk", 32'(o_blk_cnt), 32'd0);
    chk("rst_full", 32'(o_full), 32'd0);
    i_rst = 1'b0;

    // Single pattern block: latency and byte order 0x00..0x3F
    i_wr_en = 1'b1; i_data = pattern();
    @(negedge i_clk);
    i_wr_en = 1'b0;
    chk("lat_vld_early", 32'(o_data_vld), 32'd0);
    @(negedge i_clk);
    chk("lat_vld", 32'(o_data_vld), 32'd1);
    for (int j = 0; j < 64; j++) begin
      chk("pat_byte", 32'(o_data), 32'(j));
      chk("pat_cnt", 32'(o_data_cnt), 32'(64 - j));
      i_rd_en = 1'b1;
      @(negedge i_clk);
    end
    i_rd_en = 1'b0;
    chk("pat_vld_end", 32'(o_data_vld), 32'd0);
    chk("pat_cnt_end", 32'(o_data_cnt), 32'd0);

    // Six writes, no pops: fill and overflow
    for (int w = 0; w < 6; w++) begin
      i_wr_en = 1'b1; i_data = rnd_blk();
      @(negedge i_clk);
      if (w == 3) begin
        chk("fill4_blk", 32'(o_blk_cnt), 32'd3);
        chk("fill4_full", 32'(o_full), 32'd0);
      end
    end
    i_wr_en = 1'b0;
    chk("fill_full", 32'(o_full), 32'd1);
    chk("fill_blk", 32'(o_blk_cnt), 32'd4);
    chk("fill_cnt", 32'(o_data_cnt), 32'd320);
`ifdef BLK2BYTE_ERR_FLAGS_EN
    chk("fill_ovf", 32'(o_ovf), 32'd1);
`endif

    // Continuous pops over 5 blocks: no vld gap
    for (int j = 0; j < 320; j++) begin
      chk("stream_vld", 32'(o_data_vld), 32'd1);
      i_rd_en = 1'b1;
      @(negedge i_clk);
    end
    i_rd_en = 1'b0;
    chk("stream_end_vld", 32'(o_data_vld), 32'd0);

    // Write coinciding with the last pop of a block, one block queued
    do_reset();
    i_wr_en = 1'b1; i_data = rnd_blk();
    @(negedge i_clk);
    i_data = rnd_blk();
    @(negedge i_clk);
    i_wr_en = 1'b0;
    for (int j = 0; j < 63; j++) begin
      i_rd_en = 1'b1;
      @(negedge i_clk);
    end
    chk("edge_cnt_pre", 32'(o_data_cnt), 32'd65);
    i_rd_en = 1'b1; i_wr_en = 1'b1; i_data = rnd_blk();
    @(negedge i_clk);
    i_rd_en = 1'b0; i_wr_en = 1'b0;
    chk("edge_cnt_post", 32'(o_data_cnt), 32'd128);
    chk("edge_blk_post", 32'(o_blk_cnt), 32'd1);
    drain("edge_drain");

    // Pop while empty after reset
    do_reset();
    i_rd_en = 1'b1;
    @(negedge i_clk);
    i_rd_en = 1'b0;
    chk("udf_vld", 32'(o_data_vld), 32'd0);
    chk("udf_cnt", 32'(o_data_cnt), 32'd0);
    chk("udf_blk", 32'(o_blk_cnt), 32'd0);
`ifdef BLK2BYTE_ERR_FLAGS_EN
    chk("udf_flag", 32'(o_udf), 32'd1);
`endif

    // Reset mid-block with 2 blocks queued
    do_reset();
    for (int w = 0; w < 3; w++) begin
      i_wr_en = 1'b1; i_data = rnd_blk();
      @(negedge i_clk);
    end
    i_wr_en = 1'b0;
    for (int j = 0; j < 20; j++) begin
      i_rd_en = 1'b1;
      @(negedge i_clk);
    end
    chk("mid_blk", 32'(o_blk_cnt), 32'd2);
    i_rst = 1'b1; i_wr_en = 1'b1; i_data = rnd_blk();
    @(negedge i_clk);
    i_rst = 1'b0; i_rd_en = 1'b0; i_wr_en = 1'b0;
    chk("mid_rst_vld", 32'(o_data_vld), 32'd0);
    chk("mid_rst_cnt", 32'(o_data_cnt), 32'd0);
    chk("mid_rst_blk", 32'(o_blk_cnt), 32'd0);
    chk("mid_rst_data", 32'(o_data), 32'd0);
    i_wr_en = 1'b1; i_data = pattern();
    @(negedge i_clk);
    i_wr_en = 1'b0;
    @(negedge i_clk);
    chk("mid_fresh_byte0", 32'(o_data), 32'd0);
    i_rd_en = 1'b1;
    @(negedge i_clk);
    chk("mid_fresh_byte1", 32'(o_data), 32'd1);
    drain("mid_drain");

    // Random traffic, model-checked every cycle
    for (int c = 0; c < 4000; c++) begin
      i_rst   = ($urandom_range(0, 799) == 0);
      i_wr_en = ($urandom_range(0, 99) < 4);
      i_rd_en = ($urandom_range(0, 99) < 80);
      i_data  = rnd_blk();
      @(negedge i_clk);
    end
    idle_inputs();
    @(negedge i_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/blk2byte_fifo.md
Name: blk2byte_fifo

Overview:
- Wide-to-narrow FIFO. Accepts whole 512-bit blocks on a parallel write port and emits them one byte per pop on a first-word-fall-through read port.
- Counterpart of the byte-in/block-out capture FIFO: it sits on the transmit path, where a 512-bit block producer feeds a byte-serial sink.
- Byte unpacking is the exact inverse of the capture FIFO's packing, so a block round-trips byte-identically.

Parameters:
- BLK_DEPTH, 4, number of 512-bit block slots in storage; power of 2, minimum 2.
- CNT_W, 9, width of o_data_cnt; must hold (BLK_DEPTH+1)*64.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_wr_en  in  1  block write request.
- i_data  in  512  block to write.
- o_full  out  1  all BLK_DEPTH slots occupied; a write is ignored.
- i_rd_en  in  1  pop the current byte.
- o_data  out  8  current byte; valid when o_data_vld=1.
- o_data_vld  out  1  o_data holds an unread byte.
- o_data_cnt  out  CNT_W  unread bytes: slots plus streaming block.
- o_blk_cnt  out  $clog2(BLK_DEPTH)+1  occupied block slots.

Behaviour:
- Reset (i_clk edge with i_rst=1) sets the following; i_rst overrides all other inputs in the same cycle, including mid-block, and any partial block is discarded:
  - wr_ptr = 0, rd_ptr = 0 (each $clog2(BLK_DEPTH)+1 bits, wrap naturally).
  - state = IDLE, byte index idx = 0.
  - o_data = 0, o_data_vld = 0, o_full = 0, o_data_cnt = 0, o_blk_cnt = 0.
- Write:
  - Accepted when i_wr_en=1 and o_full=0: the slot at wr_ptr gets i_data, and wr_ptr increments.
  - A write while full is dropped and changes no state.
- Slot count is o_blk_cnt = wr_ptr - rd_ptr; o_full = (o_blk_cnt == BLK_DEPTH).
- The block being streamed sits in a 512-bit shift register sh and does not occupy a slot.
- Load reorder: at load, sh byte j (sh[8j+7:8j]) is taken from the slot at i_data[32*(j/4)+31-8*(j%4) -: 8], for j = 0..63. The result, relative to the original i_data:
  - byte 0 = bits [31:24], byte 1 = [23:16], byte 2 = [15:8], byte 3 = [7:0].
  - byte 4 = [63:56], and so on through byte 63 = [487:480].
- o_data = sh[7:0], a registered path.
- State machine:
  - IDLE: o_data_vld = 0. If o_blk_cnt > 0, load sh from the slot at rd_ptr, rd_ptr++, idx = 0, go to STREAM.
  - STREAM: o_data_vld = 1. On i_rd_en, sh shifts right 8 and idx++.
  - Pop with idx == 63 and o_blk_cnt > 0: load the next block in the same edge and stay in STREAM. There is no bubble, and vld stays 1.
  - Pop with idx == 63 and o_blk_cnt == 0: go to IDLE; vld = 0 on the next cycle.
- i_rd_en while o_data_vld = 0 is ignored.
- Latency: a write accepted at edge E into an empty, IDLE FIFO gives o_data_vld = 1 and the first byte after edge E+1. There is no write-to-read bypass.
- A write and a load on the same edge move both pointers, so o_blk_cnt is unchanged. A write is accepted on the edge that a load frees a slot only if o_full was 0 before that edge; o_full is evaluated pre-edge.
- o_data_cnt = 64*o_blk_cnt + (STREAM ? 64-idx : 0), registered and consistent with the other outputs every cycle. Simultaneous write and pop: +64 then -1 → net +63.
- Pointer wrap at 2*BLK_DEPTH is natural. Full and empty are distinguished by the pointer MSB.

Optional Feature:
- Macro: BLK2BYTE_ERR_FLAGS_EN.
- When defined, two outputs are added:
  - o_ovf (1 bit): sticky, set the cycle after i_wr_en=1 with o_full=1.
  - o_udf (1 bit): sticky, set the cycle after i_rd_en=1 with o_data_vld=0.
  - Both are cleared only by i_rst; reset value 0. Data-path behaviour is otherwise identical.
- When undefined, neither port exists and illegal requests are silently ignored as above.

Test Plan:
- Reset, then one write of i_data with 32-bit word k = {4k, 4k+1, 4k+2, 4k+3} (byte values) → vld rises one edge after the write; popping every cycle gives bytes 0x00,0x01,…,0x3F; o_data_cnt steps 64→0; vld drops after the 64th pop.
- Write 4 blocks back-to-back with no pops (BLK_DEPTH=4) → o_blk_cnt = 3 and o_full = 0 after the first load. A 5th write is accepted, bringing o_full to 1; a 6th write is dropped (o_ovf=1 with the macro); o_data_cnt = 320.
- 5 blocks queued, continuous pops → 320 bytes with no vld gap at block boundaries; content order matches write order.
- Write issued on the same cycle as the 64th pop of a block, with one block queued → cnt goes from 1+64 to 64+64 (one pop, +64 write, -64 next load... check cnt = 128 after the edge); o_blk_cnt unchanged.
- Pop with vld=0 after reset → no state change; o_udf = 1 with the macro, otherwise all outputs stay 0.
- i_rst asserted at idx = 20 with 2 blocks queued → next cycle all outputs are at reset values; a subsequent write streams fresh data correctly.
